// File: rtl/bitwise_logic_pkg.sv
// Shared op codes and FSM encoding for the bitwise logic unit.
package bitwise_logic_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_logic_if.sv
// Request/response handshake bundle for the bitwise logic unit.
interface bitwise_logic_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/logic_slice.sv
// Combinational bitwise operator for one slice of the operands.
import bitwise_logic_pkg::*;

module logic_slice #(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s
);
    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            OP_XNOR: y_s = ~(a_s ^ b_s);
            OP_PASS: y_s = a_s;
            OP_NOT:  y_s = ~a_s;
            default: y_s = '0;
        endcase
    end
endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-wide chunk per clock.
import bitwise_logic_pkg::*;

module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic            clk,
    input logic            rst_n,
    bitwise_logic_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] y_s;

    assign a_s = a_q[int'(cnt)*SLICE +: SLICE];
    assign b_s = b_q[int'(cnt)*SLICE +: SLICE];

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op  (op_q),
        .a_s (a_s),
        .b_s (b_s),
        .y_s (y_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Unused encoding 2'b11 falls into default and recovers to IDLE.
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: state_nx = bus.in_valid ? RUN : IDLE;
            RUN:  state_nx = (cnt == LAST) ? DONE : RUN;
            DONE: state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    cnt   <= '0;
                    op_q  <= bus.op;
                    a_q   <= bus.a;
                    b_q   <= bus.b;
                    res_q <= '0;
                end
                RUN: begin
                    res_q[int'(cnt)*SLICE +: SLICE] <= y_s;
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed and table-driven checks for bitwise_logic_unit.
import bitwise_logic_pkg::*;

module tb_bitwise_logic_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bitwise_logic_if #(.WIDTH(32)) i0 ();
    bitwise_logic_if #(.WIDTH(32)) i1 ();
    bitwise_logic_if #(.WIDTH(64)) i2 ();

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8))
        d0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    bitwise_logic_unit #(.WIDTH(32), .SLICE(32))
        d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    bitwise_logic_unit #(.WIDTH(64), .SLICE(8))
        d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(int s, logic v, logic [2:0] op,
                         logic [63:0] a, logic [63:0] b);
        case (s)
            0: begin i0.in_valid = v; i0.op = op; i0.a = a[31:0]; i0.b = b[31:0]; end
            1: begin i1.in_valid = v; i1.op = op; i1.a = a[31:0]; i1.b = b[31:0]; end
            default: begin i2.in_valid = v; i2.op = op; i2.a = a; i2.b = b; end
        endcase
    endtask

    task automatic set_ordy(int s, logic v);
        case (s)
            0: i0.out_ready = v;
            1: i1.out_ready = v;
            default: i2.out_ready = v;
        endcase
    endtask

    function automatic logic get_ov(int s);
        case (s)
            0: return i0.out_valid;
            1: return i1.out_valid;
            default: return i2.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(int s);
        case (s)
            0: return i0.in_ready;
            1: return i1.in_ready;
            default: return i2.in_ready;
        endcase
    endfunction

    function automatic logic get_zero(int s);
        case (s)
            0: return i0.zero;
            1: return i1.zero;
            default: return i2.zero;
        endcase
    endfunction

    function automatic logic [63:0] get_res(int s);
        case (s)
            0: return {32'h0, i0.result};
            1: return {32'h0, i1.result};
            default: return i2.result;
        endcase
    endfunction

    function automatic logic [63:0] ref_op(logic [2:0] op, logic [63:0] a,
                                           logic [63:0] b, int w);
        logic [63:0] y;
        logic [63:0] m;
        case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = ~(a | b);
            3'd3: y = a ^ b;
            3'd4: y = ~(a & b);
            3'd5: y = ~(a ^ b);
            3'd6: y = a;
            default: y = ~a;
        endcase
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        return y & m;
    endfunction

    task automatic wait_done(int s, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (get_ov(s)) break;
        end
    endtask

    task automatic run_op(int s, logic [2:0] op, logic [63:0] a,
                          logic [63:0] b, output int lat);
        drive(s, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(s, 1'b0, op, a, b);
        wait_done(s, lat);
    endtask

    task automatic retire(int s, string name);
        set_ordy(s, 1'b1);
        @(posedge clk); #1;
        set_ordy(s, 1'b0);
        check({name, "_ov_low"}, 64'(get_ov(s)), 64'd0);
        check({name, "_in_ready"}, 64'(get_ir(s)), 64'd1);
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] exp;
        logic [63:0] hold;

        vecs[0] = '{OP_NOR,  32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_0000, 1'b0};
        vecs[1] = '{OP_XOR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[2] = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[3] = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[4] = '{OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[5] = '{OP_XNOR, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF00F_F00F, 1'b0};
        vecs[6] = '{OP_PASS, 32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE, 1'b0};
        vecs[7] = '{OP_NOT,  32'hFFFF_0000, 32'hABCD_EF01, 32'h0000_FFFF, 1'b0};

        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 3'd0, 64'd0, 64'd0);
            set_ordy(s, 1'b0);
        end

        // reset held two cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(i0.in_ready), 64'd1);
        check("rst_out_valid", 64'(i0.out_valid), 64'd0);
        check("rst_result", 64'(i0.result), 64'd0);
        check("rst_zero", 64'(i0.zero), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), lat);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'd4);
            check($sformatf("v%0d_res", i), 64'(i0.result), 64'(vecs[i].res));
            check($sformatf("v%0d_zero", i), 64'(i0.zero), 64'(vecs[i].zero));
            retire(0, $sformatf("v%0d", i));
            @(posedge clk); #1;
        end

        // stall in DONE with out_ready low
        run_op(0, OP_XOR, 64'hDEAD_BEEF, 64'hDEAD_BEEF, lat);
        check("stall_zero", 64'(i0.zero), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, OP_OR, 64'h5555_5555, 64'h1);
            @(posedge clk); #1;
            check("stall_ov", 64'(i0.out_valid), 64'd1);
            check("stall_res", 64'(i0.result), 64'd0);
        end
        retire(0, "stall");
        check("stall_res_kept", 64'(i0.result), 64'd0);

        // no accept on the retire edge
        run_op(0, OP_PASS, 64'h0000_00A5, 64'd0, lat);
        drive(0, 1'b1, OP_NOT, 64'd0, 64'd0);
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        set_ordy(0, 1'b0);
        check("handoff_idle", 64'(i0.in_ready), 64'd1);
        check("handoff_res", 64'(i0.result), 64'h0000_00A5);
        @(posedge clk); #1;
        drive(0, 1'b0, OP_NOT, 64'd0, 64'd0);
        check("handoff_run", 64'(i0.in_ready), 64'd0);
        wait_done(0, lat);
        check("handoff_lat", 64'(lat), 64'd4);
        check("handoff_res2", 64'(i0.result), 64'hFFFF_FFFF);
        retire(0, "handoff");

        // reset in the middle of RUN
        drive(0, 1'b1, OP_AND, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, OP_AND, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(i0.in_ready), 64'd1);
        check("midrst_result", 64'(i0.result), 64'd0);
        check("midrst_zero", 64'(i0.zero), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i0.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_ov", 64'(seen), 64'd0);

        // operands changed during RUN are ignored
        drive(0, 1'b1, OP_OR, 64'h1, 64'h2);
        @(posedge clk); #1;
        drive(0, 1'b0, OP_NOT, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        wait_done(0, lat);
        check("chg_lat", 64'(lat), 64'd4);
        check("chg_res", 64'(i0.result), 64'h3);
        retire(0, "chg");
        @(posedge clk); #1;

        // parameter sweep against the reference model
        for (int s = 1; s < 3; s++) begin
            for (int op = 0; op < 8; op++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (s == 1) begin
                    ra[63:32] = '0;
                    rb[63:32] = '0;
                end
                exp = ref_op(3'(op), ra, rb, (s == 1) ? 32 : 64);
                run_op(s, 3'(op), ra, rb, lat);
                check($sformatf("sw%0d_op%0d_lat", s, op), 64'(lat),
                      (s == 1) ? 64'd1 : 64'd8);
                hold = get_res(s);
                check($sformatf("sw%0d_op%0d_res", s, op), hold, exp);
                check($sformatf("sw%0d_op%0d_zero", s, op),
                      64'(get_zero(s)), 64'(exp == 64'd0));
                retire(s, $sformatf("sw%0d_op%0d", s, op));
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
